// File: rtl/axis_pkt_arbiter.sv
// 2:1 AXI4-Stream packet arbiter: round-robin per packet, one registered output stage,
// per-port completed-packet counters and a host enable that gates new grants only.
module axis_pkt_arbiter #(
    parameter int TBITS    = 32,
    parameter int TBYTE    = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                S0_TVALID,
    output logic                S0_TREADY,
    input  logic [TBITS-1:0]    S0_TDATA,
    input  logic [TBYTE-1:0]    S0_TKEEP,
    input  logic                S0_TLAST,
    input  logic                S0_TUSER,
    input  logic                S1_TVALID,
    output logic                S1_TREADY,
    input  logic [TBITS-1:0]    S1_TDATA,
    input  logic [TBYTE-1:0]    S1_TKEEP,
    input  logic                S1_TLAST,
    input  logic                S1_TUSER,
    output logic                M_TVALID,
    input  logic                M_TREADY,
    output logic [TBITS-1:0]    M_TDATA,
    output logic [TBYTE-1:0]    M_TKEEP,
    output logic                M_TLAST,
    output logic                M_TUSER,
    output logic                M_TID,
    input  logic                cfg_en,
    output logic                busy,
    output logic [CNT_BITS-1:0] pkt_cnt0,
    output logic [CNT_BITS-1:0] pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic [TBITS-1:0]    m_tdata_q, m_tdata_d;
    logic [TBYTE-1:0]    m_tkeep_q, m_tkeep_d;
    logic                m_tlast_q, m_tlast_d;
    logic                m_tuser_q, m_tuser_d;
    logic                m_tid_q, m_tid_d;
    logic [CNT_BITS-1:0] cnt0_q, cnt0_d;
    logic [CNT_BITS-1:0] cnt1_q, cnt1_d;

    logic ordy;
    logic load0, load1;

    // Handshake: a beat moves on a cycle where VALID and READY are both high at the
    // rising edge; the source holds VALID and payload stable until that happens.
    assign ordy  = ~m_tvalid_q | M_TREADY;
    assign load0 = S0_TVALID & S0_TREADY;
    assign load1 = S1_TVALID & S1_TREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (cfg_en && (S0_TVALID || S1_TVALID)) begin
                    if (S0_TVALID && S1_TVALID) begin
                        state_d = last_q ? GNT0 : GNT1;
                    end else begin
                        state_d = S0_TVALID ? GNT0 : GNT1;
                    end
                end
            end
            GNT0: begin
                if (load0 && S0_TLAST) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                if (load1 && S1_TLAST) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        S0_TREADY = 1'b0;
        S1_TREADY = 1'b0;
        busy      = 1'b0;
        case (state_q)
            GNT0: begin
                S0_TREADY = ordy;
                busy      = 1'b1;
            end
            GNT1: begin
                S1_TREADY = ordy;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Output register: loads from whichever port holds the grant, drains when taken.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        m_tid_d    = m_tid_q;
        if (load1) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = S1_TDATA;
            m_tkeep_d  = S1_TKEEP;
            m_tlast_d  = S1_TLAST;
            m_tuser_d  = S1_TUSER;
            m_tid_d    = 1'b1;
        end else if (load0) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = S0_TDATA;
            m_tkeep_d  = S0_TKEEP;
            m_tlast_d  = S0_TLAST;
            m_tuser_d  = S0_TUSER;
            m_tid_d    = 1'b0;
        end else if (M_TREADY) begin
            m_tvalid_d = 1'b0;
        end
        cnt0_d = cnt0_q + CNT_BITS'(load0 && S0_TLAST);
        cnt1_d = cnt1_q + CNT_BITS'(load1 && S1_TLAST);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            m_tid_q    <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
            m_tid_q    <= m_tid_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign M_TVALID = m_tvalid_q;
    assign M_TDATA  = m_tdata_q;
    assign M_TKEEP  = m_tkeep_q;
    assign M_TLAST  = m_tlast_q;
    assign M_TUSER  = m_tuser_q;
    assign M_TID    = m_tid_q;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: arbitration vector table, directed packet sequences and
// randomized traffic checked against a packet-order scoreboard.
module tb_axis_pkt_arbiter;

    localparam int TBITS    = 32;
    localparam int TBYTE    = 4;
    localparam int CNT_BITS = 8;   // narrow counters keep the wrap sequence short
    localparam int BW       = TBITS + TBYTE + 2;
    localparam int OW       = BW + 1;

    logic                ACLK = 1'b0;
    logic                ARESET = 1'b1;
    logic                S0_TVALID = 1'b0, S0_TREADY;
    logic [TBITS-1:0]    S0_TDATA = '0;
    logic [TBYTE-1:0]    S0_TKEEP = '0;
    logic                S0_TLAST = 1'b0, S0_TUSER = 1'b0;
    logic                S1_TVALID = 1'b0, S1_TREADY;
    logic [TBITS-1:0]    S1_TDATA = '0;
    logic [TBYTE-1:0]    S1_TKEEP = '0;
    logic                S1_TLAST = 1'b0, S1_TUSER = 1'b0;
    logic                M_TVALID, M_TREADY = 1'b1;
    logic [TBITS-1:0]    M_TDATA;
    logic [TBYTE-1:0]    M_TKEEP;
    logic                M_TLAST, M_TUSER, M_TID;
    logic                cfg_en = 1'b1;
    logic                busy;
    logic [CNT_BITS-1:0] pkt_cnt0, pkt_cnt1;

    axis_pkt_arbiter #(.TBITS(TBITS), .TBYTE(TBYTE), .CNT_BITS(CNT_BITS)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S0_TVALID(S0_TVALID), .S0_TREADY(S0_TREADY), .S0_TDATA(S0_TDATA),
        .S0_TKEEP(S0_TKEEP), .S0_TLAST(S0_TLAST), .S0_TUSER(S0_TUSER),
        .S1_TVALID(S1_TVALID), .S1_TREADY(S1_TREADY), .S1_TDATA(S1_TDATA),
        .S1_TKEEP(S1_TKEEP), .S1_TLAST(S1_TLAST), .S1_TUSER(S1_TUSER),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
        .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .M_TUSER(M_TUSER), .M_TID(M_TID),
        .cfg_en(cfg_en), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 ACLK = ~ACLK;

    // Source beats are {user, last, keep, data}; expected output beats prepend the port id.
    logic [BW-1:0] q0[$], q1[$];
    logic [OW-1:0] exp_q[$];
    int            out_cyc[$];
    int unsigned   vpct0 = 100, vpct1 = 100, rpct = 100;
    bit            pat_mode = 1'b0;
    int            pat_i = 0;
    bit            hold0 = 1'b0, hold1 = 1'b0, stall_q = 1'b0;
    logic [OW-1:0] prev_obs = '0;
    bit            rst_req = 1'b0, en_req = 1'b1;
    int            cyc_cnt = 0, acc_cnt0 = 0, acc_cnt1 = 0;
    int            n_cmp = 0, n_bad = 0;

    typedef struct {
        bit v0, v1, en, pre;
        bit exp_busy, exp_r0, exp_r1;
    } arb_vec_t;
    arb_vec_t vecs[8];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [BW-1:0] mk_beat(input int i, input int len, input logic [TBITS-1:0] base,
                                              input logic [TBYTE-1:0] keep, input logic user);
        logic [TBITS-1:0] d;
        logic u, l;
        d = base + TBITS'(i);
        u = user && (i == 0);
        l = (i == len - 1);
        return {u, l, keep, d};
    endfunction

    task automatic add_pkt(input bit port, input int len, input logic [TBITS-1:0] base,
                           input logic [TBYTE-1:0] keep, input logic user, input bit to_src, input bit to_exp);
        for (int i = 0; i < len; i++) begin
            logic [BW-1:0] b;
            b = mk_beat(i, len, base, keep, user);
            if (to_src) begin
                if (port) q1.push_back(b);
                else q0.push_back(b);
            end
            if (to_exp) exp_q.push_back({port, b});
        end
    endtask

    // One clock: drive at the falling edge, sample 2 time units later (before the rising edge).
    task automatic cycle();
        bit acc0, acc1;
        logic [OW-1:0] obs, e;
        logic [63:0] junk;
        @(negedge ACLK);
        ARESET = rst_req;
        cfg_en = en_req;
        if (!hold0) S0_TVALID = (q0.size() > 0) && ($urandom_range(1, 100) <= vpct0);
        if (!hold1) S1_TVALID = (q1.size() > 0) && ($urandom_range(1, 100) <= vpct1);
        junk = {$urandom, $urandom};
        if (S0_TVALID) {S0_TUSER, S0_TLAST, S0_TKEEP, S0_TDATA} = q0[0];
        else {S0_TUSER, S0_TLAST, S0_TKEEP, S0_TDATA} = junk[BW-1:0];
        junk = {$urandom, $urandom};
        if (S1_TVALID) {S1_TUSER, S1_TLAST, S1_TKEEP, S1_TDATA} = q1[0];
        else {S1_TUSER, S1_TLAST, S1_TKEEP, S1_TDATA} = junk[BW-1:0];
        if (pat_mode) begin
            M_TREADY = (pat_i % 3 == 0);
            pat_i++;
        end else begin
            M_TREADY = ($urandom_range(1, 100) <= rpct);
        end
        #2;
        acc0 = S0_TVALID && S0_TREADY;
        acc1 = S1_TVALID && S1_TREADY;
        obs  = {M_TID, M_TUSER, M_TLAST, M_TKEEP, M_TDATA};
        if (stall_q) chk(M_TVALID && obs == prev_obs, "hold_stable", {M_TVALID, obs}, {1'b1, prev_obs});
        if (M_TVALID && !M_TREADY) chk(!S0_TREADY && !S1_TREADY, "stall_tready", {S0_TREADY, S1_TREADY}, 2'b00);
        if (M_TVALID && M_TREADY) begin
            out_cyc.push_back(cyc_cnt);
            chk(exp_q.size() != 0, "beat_expected", obs, 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(obs == e, "beat", obs, e);
            end
        end
        stall_q  = M_TVALID && !M_TREADY && !ARESET;
        prev_obs = obs;
        if (acc0) begin
            void'(q0.pop_front());
            acc_cnt0++;
        end
        if (acc1) begin
            void'(q1.pop_front());
            acc_cnt1++;
        end
        hold0 = S0_TVALID && !acc0;
        hold1 = S1_TVALID && !acc1;
        cyc_cnt++;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESET = 1'b1;
        S0_TVALID = 1'b0;
        S1_TVALID = 1'b0;
        M_TREADY = 1'b1;
        q0.delete(); q1.delete(); exp_q.delete(); out_cyc.delete();
        hold0 = 0; hold1 = 0; stall_q = 0; acc_cnt0 = 0; acc_cnt1 = 0;
        pat_mode = 0; pat_i = 0; rst_req = 0; en_req = 1; cfg_en = 1'b1;
        vpct0 = 100; vpct1 = 100; rpct = 100;
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    task automatic run_until_done(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk(n < max_cyc, name, n, max_cyc);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_acc(input bit port, input int cnt, input int max_cyc, input string name);
        int n;
        n = 0;
        while (((port ? acc_cnt1 : acc_cnt0) < cnt) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk(n < max_cyc, name, n, max_cyc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, sent0;

        vecs[0] = '{0, 0, 1, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 1, 0, 1, 1, 0};
        vecs[2] = '{0, 1, 1, 0, 1, 0, 1};
        vecs[3] = '{1, 1, 1, 0, 1, 1, 0};
        vecs[4] = '{1, 1, 0, 0, 0, 0, 0};
        vecs[5] = '{1, 1, 1, 1, 1, 0, 1};
        vecs[6] = '{0, 1, 0, 1, 0, 0, 0};
        vecs[7] = '{1, 0, 1, 1, 1, 1, 0};

        // Reset state
        do_reset();
        #1;
        chk({M_TVALID, M_TLAST, M_TUSER, M_TID, S0_TREADY, S1_TREADY, busy} == 7'd0, "reset_ctrl",
            {M_TVALID, M_TLAST, M_TUSER, M_TID, S0_TREADY, S1_TREADY, busy}, 0);
        chk(M_TDATA == '0 && M_TKEEP == '0, "reset_data", {M_TKEEP, M_TDATA}, 0);
        chk(pkt_cnt0 == '0 && pkt_cnt1 == '0, "reset_cnt", {pkt_cnt0, pkt_cnt1}, 0);

        // Grant decision one cycle after valids are presented in IDLE
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (vecs[i].pre) begin
                add_pkt(0, 1, 32'h55, 4'hF, 1'b0, 1, 1);
                run_until_done(20, "pre_pkt_done");
            end
            @(negedge ACLK);
            cfg_en = vecs[i].en;
            S0_TVALID = vecs[i].v0;
            S1_TVALID = vecs[i].v1;
            S0_TLAST = 1'b1;
            S1_TLAST = 1'b1;
            M_TREADY = 1'b1;
            @(negedge ACLK);
            #1;
            chk({busy, S0_TREADY, S1_TREADY} == {vecs[i].exp_busy, vecs[i].exp_r0, vecs[i].exp_r1},
                $sformatf("arb_vec%0d", i), {busy, S0_TREADY, S1_TREADY},
                {vecs[i].exp_busy, vecs[i].exp_r0, vecs[i].exp_r1});
        end

        // 4-beat packet on S0 at full rate
        do_reset();
        add_pkt(0, 4, 32'h10, 4'hF, 1'b1, 1, 1);
        c0 = cyc_cnt;
        cycle();
        chk(!busy && !S0_TREADY, "idle_first_cycle", {busy, S0_TREADY}, 0);
        cycle();
        chk(busy && S0_TREADY, "grant_latency", {busy, S0_TREADY}, 2'b11);
        run_until_done(20, "s0_pkt_done");
        chk(out_cyc.size() == 4, "s0_beat_count", out_cyc.size(), 4);
        if (out_cyc.size() == 4)
            chk(out_cyc[0] == c0 + 2 && out_cyc[3] == c0 + 5, "s0_back_to_back",
                {32'(out_cyc[0] - c0), 32'(out_cyc[3] - c0)}, {32'd2, 32'd5});
        chk(pkt_cnt0 == 1 && pkt_cnt1 == 0, "s0_pkt_cnt", {pkt_cnt0, pkt_cnt1}, {8'd1, 8'd0});
        chk(!busy, "s0_busy_clear", busy, 0);

        // Both ports hold packets: strict alternation starting at S0
        do_reset();
        add_pkt(0, 3, 32'hA00, 4'hF, 1'b1, 1, 1);
        add_pkt(1, 3, 32'hB00, 4'h3, 1'b0, 1, 1);
        add_pkt(0, 3, 32'hA10, 4'h7, 1'b0, 1, 1);
        add_pkt(1, 3, 32'hB10, 4'hF, 1'b1, 1, 1);
        run_until_done(60, "alt_done");
        chk(pkt_cnt0 == 2 && pkt_cnt1 == 2, "alt_cnt", {pkt_cnt0, pkt_cnt1}, {8'd2, 8'd2});

        // S1 5-beat packet under M_TREADY pattern 1,0,0
        do_reset();
        pat_mode = 1'b1;
        add_pkt(1, 5, 32'hC0, 4'h9, 1'b1, 1, 1);
        run_until_done(60, "stall_done");
        chk(pkt_cnt1 == 1, "stall_cnt", pkt_cnt1, 1);

        // cfg_en dropped mid-packet: S0 finishes, S1 waits for re-enable
        do_reset();
        add_pkt(0, 4, 32'h300, 4'hF, 1'b0, 1, 1);
        add_pkt(1, 2, 32'h400, 4'hF, 1'b0, 1, 0);
        wait_acc(0, 1, 20, "en_first_beat");
        en_req = 1'b0;
        run_n(12);
        chk(exp_q.size() == 0 && acc_cnt0 == 4, "en_s0_complete", {32'(exp_q.size()), 32'(acc_cnt0)}, {32'd0, 32'd4});
        chk(acc_cnt1 == 0 && !busy, "en_s1_blocked", {acc_cnt1, busy}, 0);
        en_req = 1'b1;
        add_pkt(1, 2, 32'h400, 4'hF, 1'b0, 0, 1);
        run_until_done(20, "en_s1_done");
        chk(pkt_cnt0 == 1 && pkt_cnt1 == 1, "en_cnt", {pkt_cnt0, pkt_cnt1}, {8'd1, 8'd1});

        // Reset in the middle of an S1 packet, after an S0 packet made S1 the preferred port
        do_reset();
        add_pkt(0, 1, 32'h500, 4'hF, 1'b0, 1, 1);
        run_until_done(20, "rst_pre_done");
        add_pkt(1, 4, 32'h600, 4'hF, 1'b1, 1, 0);
        exp_q.push_back({1'b1, mk_beat(0, 4, 32'h600, 4'hF, 1'b1)});
        wait_acc(1, 1, 20, "rst_first_beat");
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        q0.delete(); q1.delete();
        hold0 = 1'b0; hold1 = 1'b0;
        cycle();
        chk({M_TVALID, S0_TREADY, S1_TREADY, busy} == 4'd0, "post_reset_ctrl",
            {M_TVALID, S0_TREADY, S1_TREADY, busy}, 0);
        chk(pkt_cnt0 == 0 && pkt_cnt1 == 0, "post_reset_cnt", {pkt_cnt0, pkt_cnt1}, 0);
        add_pkt(0, 2, 32'h700, 4'hF, 1'b0, 1, 1);
        add_pkt(1, 2, 32'h800, 4'hF, 1'b0, 1, 1);
        run_until_done(30, "post_reset_done");

        // Counter wrap on S0 while S1 count stays put
        do_reset();
        for (int i = 0; i < 3; i++) add_pkt(1, 1, 32'h900 + 32'(i), 4'hF, 1'b0, 1, 1);
        run_until_done(30, "wrap_s1_done");
        sent0 = 0;
        for (int i = 0; i < (1 << CNT_BITS) - 1; i++) begin
            add_pkt(0, 1, 32'h1000 + 32'(i), 4'hF, 1'b0, 1, 1);
            sent0++;
        end
        run_until_done(2000, "wrap_s0_done");
        chk(pkt_cnt0 == CNT_BITS'(sent0), "wrap_pre_cnt0", pkt_cnt0, CNT_BITS'(sent0));
        add_pkt(0, 1, 32'h2000, 4'hF, 1'b0, 1, 1);
        sent0++;
        run_until_done(20, "wrap_last_done");
        chk(pkt_cnt0 == CNT_BITS'(sent0), "wrap_cnt0", pkt_cnt0, CNT_BITS'(sent0));
        chk(pkt_cnt1 == 3, "wrap_cnt1", pkt_cnt1, 3);

        // Random traffic, both ports always offering: packets alternate S0,S1,...
        do_reset();
        rpct = 60;
        for (int k = 0; k < 6; k++) begin
            add_pkt(0, $urandom_range(1, 6), $urandom, TBYTE'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1, 1);
            add_pkt(1, $urandom_range(1, 6), $urandom, TBYTE'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1, 1);
        end
        run_until_done(2000, "rand_alt_done");
        chk(pkt_cnt0 == 6 && pkt_cnt1 == 6, "rand_alt_cnt", {pkt_cnt0, pkt_cnt1}, {8'd6, 8'd6});

        // Random traffic, S1 only, with source gaps and backpressure
        do_reset();
        vpct1 = 50;
        rpct = 50;
        for (int k = 0; k < 8; k++)
            add_pkt(1, $urandom_range(1, 7), $urandom, TBYTE'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1, 1);
        run_until_done(2000, "rand_s1_done");
        chk(pkt_cnt0 == 0 && pkt_cnt1 == 8, "rand_s1_cnt", {pkt_cnt0, pkt_cnt1}, {8'd0, 8'd8});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
